// File: rtl/midi_uart_transmitter.sv
// MIDI serial output: ready/valid byte FIFO feeding an 8N1 UART serializer.
// Optional running-status filter at pop time: define MIDI_RUNNING_STATUS_EN.
`timescale 1ns/1ps
module midi_uart_transmitter #(
  parameter int unsigned CLOCK_FREQUENCY = 50_000_000,
  parameter int unsigned BAUD_RATE       = 31_250,
  parameter int unsigned FIFO_DEPTH      = 4,
  localparam int unsigned BYTE_WIDTH     = 8
) (
  input  logic                  clock_50_000_000,
  input  logic                  reset,
  input  logic [BYTE_WIDTH-1:0] data_out,
  input  logic                  data_out_valid,
  output logic                  data_out_ready,
  output logic                  uart_tx,
  output logic                  busy
);

  localparam int unsigned BIT_CYCLES = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int unsigned BAUD_W     = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W      = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state, state_n;
  logic [BAUD_W-1:0]     baud, baud_n;
  logic [2:0]            bit_idx, bit_idx_n;
  logic [BYTE_WIDTH-1:0] shift, shift_n;
  logic                  tx, tx_n;

  logic [BYTE_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr, wr_ptr;
  logic [CNT_W-1:0]      count, count_n;
  logic [BYTE_WIDTH-1:0] head;
  logic                  full, empty, push, pop, drop, bit_end;

  assign head    = mem[rd_ptr];
  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign push    = data_out_valid && !full;
  assign bit_end = (baud == BAUD_W'(BIT_CYCLES - 1));

  assign data_out_ready = !full;
  assign uart_tx        = tx;
  assign busy           = (state != IDLE) || !empty;

`ifdef MIDI_RUNNING_STATUS_EN
  logic [BYTE_WIDTH-1:0] rs, rs_n;

  // A repeated channel-status byte is redundant on the wire and is dropped.
  assign drop = (head >= 8'h80) && (head <= 8'hEF) && (head == rs);

  always_comb begin
    rs_n = rs;
    if (pop && !drop) begin
      if (head >= 8'h80 && head <= 8'hEF) begin
        rs_n = head;
      end else if (head >= 8'hF0 && head <= 8'hF7) begin
        rs_n = '0;
      end
    end
  end

  always_ff @(posedge clock_50_000_000) begin
    if (reset) begin
      rs <= '0;
    end else begin
      rs <= rs_n;
    end
  end
`else
  assign drop = 1'b0;
`endif

  always_comb begin
    count_n = count;
    case ({push, pop})
      2'b10:   count_n = count + CNT_W'(1);
      2'b01:   count_n = count - CNT_W'(1);
      default: count_n = count;
    endcase
  end

  // Next-state / serializer control; a pop either loads a frame or discards the head.
  always_comb begin
    state_n   = state;
    baud_n    = baud;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    tx_n      = tx;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (!empty) begin
          pop = 1'b1;
          if (!drop) begin
            shift_n = head;
            baud_n  = '0;
            state_n = START;
            tx_n    = 1'b0;
          end
        end
      end
      START: begin
        if (bit_end) begin
          baud_n    = '0;
          bit_idx_n = '0;
          state_n   = DATA;
          tx_n      = shift[0];
        end else begin
          baud_n = baud + BAUD_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            shift_n   = shift >> 1;
            bit_idx_n = bit_idx + 3'd1;
            tx_n      = shift[1];
          end
        end else begin
          baud_n = baud + BAUD_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_n = '0;
          if (!empty) begin
            pop = 1'b1;
            if (!drop) begin
              shift_n = head;
              state_n = START;
              tx_n    = 1'b0;
            end else begin
              state_n = IDLE;
              tx_n    = 1'b1;
            end
          end else begin
            state_n = IDLE;
            tx_n    = 1'b1;
          end
        end else begin
          baud_n = baud + BAUD_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock_50_000_000) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      tx      <= tx_n;
      count   <= count_n;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Storage needs no reset: occupancy and pointers define validity.
  always_ff @(posedge clock_50_000_000) begin
    if (push) mem[wr_ptr] <= data_out;
  end

endmodule

// File: tb/tb_midi_uart_transmitter.sv
// Bench for midi_uart_transmitter: line decoder + byte-stream reference model.
`timescale 1ns/1ps
module tb_midi_uart_transmitter;
  localparam int unsigned CLK_HZ = 800_000;
  localparam int unsigned BAUD   = 100_000;
  localparam int unsigned BC     = CLK_HZ / BAUD;
  localparam int unsigned DEPTH  = 4;

  typedef logic [7:0] bq_t [$];

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data = 8'h00;
  logic       valid = 1'b0;
  logic       ready, tx, busy;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  bq_t rx_q;
  int  start_q[$];

  midi_uart_transmitter #(
    .CLOCK_FREQUENCY(CLK_HZ),
    .BAUD_RATE      (BAUD),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clock_50_000_000(clk),
    .reset           (reset),
    .data_out        (data),
    .data_out_valid  (valid),
    .data_out_ready  (ready),
    .uart_tx         (tx),
    .busy            (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected byte stream on the wire for a sequence of accepted bytes.
  function automatic bq_t model(input bq_t seq);
    bq_t out;
`ifdef MIDI_RUNNING_STATUS_EN
    logic [7:0] rs;
    rs = 8'h00;
`endif
    out = {};
    foreach (seq[i]) begin
`ifdef MIDI_RUNNING_STATUS_EN
      if (seq[i] >= 8'h80 && seq[i] <= 8'hEF) begin
        if (seq[i] == rs) continue;
        rs = seq[i];
      end else if (seq[i] >= 8'hF0 && seq[i] <= 8'hF7) begin
        rs = 8'h00;
      end
`endif
      out.push_back(seq[i]);
    end
    return out;
  endfunction

  // Line decoder: samples bit centres, verifies framing, records bytes and start cycles.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!reset && tx === 1'b0) begin
        int t0;
        logic [7:0] b;
        bit ab;
        t0 = cyc; b = 8'h00; ab = 1'b0;
        for (int k = 0; k < int'(BC / 2); k++) begin @(negedge clk); if (reset) ab = 1'b1; end
        if (!ab) begin
          n_total++;
          if (tx !== 1'b0) $display("FAIL start_bit: line=%b required 0 at cycle %0d", tx, cyc);
          else n_pass++;
        end
        for (int i = 0; i < 8; i++) begin
          for (int k = 0; k < int'(BC); k++) begin @(negedge clk); if (reset) ab = 1'b1; end
          b[i] = tx;
        end
        for (int k = 0; k < int'(BC); k++) begin @(negedge clk); if (reset) ab = 1'b1; end
        if (!ab) begin
          n_total++;
          if (tx !== 1'b1) $display("FAIL stop_bit: line=%b required 1 at cycle %0d", tx, cyc);
          else n_pass++;
          rx_q.push_back(b);
          start_q.push_back(t0);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    rx_q.delete();
    start_q.delete();
  endtask

  // Holds valid high across the sequence; reports ready seen just after the (DEPTH+1)th accept.
  task automatic push_seq(input bq_t seq, output bit ok, output logic ready_full);
    int idx, g;
    bit seen;
    idx = 0; g = 0; seen = 1'b0; ready_full = 1'bx;
    @(negedge clk);
    valid = 1'b1; data = seq[0];
    while (idx < seq.size() && g < int'(40 * BC) * (seq.size() + 1)) begin
      if (ready) idx++;
      @(negedge clk); g++;
      if (idx == int'(DEPTH) + 1 && !seen) begin seen = 1'b1; ready_full = ready; end
      if (idx < seq.size()) data = seq[idx]; else valid = 1'b0;
    end
    valid = 1'b0;
    ok = (idx == seq.size());
  endtask

  task automatic wait_idle(output bit ok);
    int g;
    g = 0;
    while (busy && g < int'(20 * BC * (DEPTH + 4))) begin @(negedge clk); g++; end
    ok = !busy;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    n_total++; if (tx !== 1'b1)    $display("FAIL reset_tx: got %b want 1", tx);    else n_pass++;
    n_total++; if (ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready); else n_pass++;
    n_total++; if (busy !== 1'b0)  $display("FAIL reset_busy: got %b want 0", busy);  else n_pass++;
  endtask

  // Cycle-exact waveform of one frame from an idle, empty transmitter.
  task automatic test_single();
    logic [7:0] vals [2];
    vals[0] = 8'h90;
    vals[1] = 8'($urandom_range(0, 127));
    for (int t = 0; t < 2; t++) begin
      logic [7:0] v;
      int errs;
      v = vals[t]; errs = 0;
      do_reset();
      data = v; valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      valid = 1'b0;
      for (int n = 0; n <= int'(10 * BC) + 1; n++) begin
        logic et, eb;
        int bp;
        bp = (n - 1) / int'(BC);
        if (n == 0 || n > int'(10 * BC)) et = 1'b1;
        else if (bp == 0) et = 1'b0;
        else if (bp == 9) et = 1'b1;
        else et = v[bp - 1];
        eb = (n <= int'(10 * BC));
        n_total++;
        if (tx !== et) begin errs++; if (errs < 4) $display("FAIL single_tx: byte %h n=%0d got %b want %b", v, n, tx, et); end
        else n_pass++;
        n_total++;
        if (busy !== eb) begin errs++; if (errs < 4) $display("FAIL single_busy: byte %h n=%0d got %b want %b", v, n, busy, eb); end
        else n_pass++;
        @(negedge clk);
      end
      n_total++;
      if (rx_q.size() != 1 || rx_q[0] !== v) $display("FAIL single_rx: got %0d bytes first %h want 1 byte %h", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00, v);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    bq_t seq, exp;
    bit ok;
    logic rf;
    do_reset();
    seq = {};
    for (int i = 0; i < 6; i++) seq.push_back(8'($urandom_range(0, 127)));
    exp = model(seq);
    push_seq(seq, ok, rf);
    n_total++; if (!ok) $display("FAIL b2b_accept: accepted fewer than %0d bytes in budget", seq.size()); else n_pass++;
    n_total++; if (rf !== 1'b0) $display("FAIL b2b_full_ready: got %b want 0", rf); else n_pass++;
    wait_idle(ok);
    n_total++; if (!ok) $display("FAIL b2b_idle: busy still %b", busy); else n_pass++;
    n_total++;
    if (rx_q.size() != exp.size()) $display("FAIL b2b_count: got %0d want %0d", rx_q.size(), exp.size());
    else n_pass++;
    for (int i = 0; i < exp.size(); i++) begin
      n_total++;
      if (i >= rx_q.size() || rx_q[i] !== exp[i]) $display("FAIL b2b_byte%0d: got %h want %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp[i]);
      else n_pass++;
    end
    for (int i = 1; i < start_q.size(); i++) begin
      n_total++;
      if (start_q[i] - start_q[i-1] != int'(10 * BC)) $display("FAIL b2b_gap%0d: got %0d want %0d", i, start_q[i] - start_q[i-1], 10 * BC);
      else n_pass++;
    end
  endtask

  task automatic test_running_status();
    bq_t seqs [4];
    int  exp_n [3];
`ifdef MIDI_RUNNING_STATUS_EN
    exp_n = '{5, 5, 6};
`else
    exp_n = '{6, 6, 6};
`endif
    seqs[0] = '{8'h90, 8'h3C, 8'h64, 8'h90, 8'h3E, 8'h64};
    seqs[1] = '{8'h90, 8'h3C, 8'h64, 8'hF8, 8'h90, 8'h40};
    seqs[2] = '{8'h90, 8'h3C, 8'h64, 8'hF6, 8'h90, 8'h40};
    seqs[3] = {};
    for (int i = 0; i < 10; i++) begin
      case ($urandom_range(0, 3))
        0:       seqs[3].push_back(8'h90);
        1:       seqs[3].push_back(8'($urandom_range(8'h00, 8'h7F)));
        2:       seqs[3].push_back(8'($urandom_range(8'hF0, 8'hFF)));
        default: seqs[3].push_back(8'($urandom_range(8'h80, 8'hEF)));
      endcase
    end
    seqs[3].push_back(8'h11);
    for (int s = 0; s < 4; s++) begin
      bq_t exp;
      bit ok;
      logic rf;
      do_reset();
      exp = model(seqs[s]);
      push_seq(seqs[s], ok, rf);
      wait_idle(ok);
      n_total++; if (!ok) $display("FAIL rs%0d_idle: busy still %b", s, busy); else n_pass++;
      if (s < 3) begin
        n_total++;
        if (rx_q.size() != exp_n[s]) $display("FAIL rs%0d_frames: got %0d want %0d", s, rx_q.size(), exp_n[s]);
        else n_pass++;
      end
      n_total++;
      if (rx_q.size() != exp.size()) $display("FAIL rs%0d_count: got %0d want %0d", s, rx_q.size(), exp.size());
      else n_pass++;
      for (int i = 0; i < exp.size(); i++) begin
        n_total++;
        if (i >= rx_q.size() || rx_q[i] !== exp[i]) $display("FAIL rs%0d_byte%0d: got %h want %h", s, i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_midframe();
    bq_t seq;
    bit ok;
    logic rf;
    int g, lows, busies;
    do_reset();
    seq = '{8'($urandom_range(0, 127)), 8'($urandom_range(0, 127)), 8'($urandom_range(0, 127))};
    push_seq(seq, ok, rf);
    g = 0;
    while (tx !== 1'b0 && g < int'(4 * BC)) begin @(negedge clk); g++; end
    n_total++; if (tx !== 1'b0) $display("FAIL mid_start: line=%b want 0", tx); else n_pass++;
    repeat (4 * BC + 3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_total++; if (tx !== 1'b1)    $display("FAIL mid_tx: got %b want 1", tx);       else n_pass++;
    n_total++; if (busy !== 1'b0)  $display("FAIL mid_busy: got %b want 0", busy);   else n_pass++;
    n_total++; if (ready !== 1'b1) $display("FAIL mid_ready: got %b want 1", ready); else n_pass++;
    reset = 1'b0;
    lows = 0; busies = 0;
    repeat (30 * BC) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
      if (busy !== 1'b0) busies++;
    end
    n_total++; if (lows != 0)   $display("FAIL mid_quiet: %0d low cycles want 0", lows);     else n_pass++;
    n_total++; if (busies != 0) $display("FAIL mid_busy_after: %0d busy cycles want 0", busies); else n_pass++;
    n_total++; if (rx_q.size() != 0) $display("FAIL mid_frames: got %0d want 0", rx_q.size()); else n_pass++;
  endtask

  initial begin
    #(900_000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_running_status();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
